serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter. Produces the single-bit serial stream that a downstream D flip-flop or serial receiver samples.
- Accepts one DATA_W-bit word per valid/ready handshake and emits a start bit, the data bits LSB first, then a stop bit. Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between lab stimulus/control logic and the serial line feeding the sampling flip-flops.

Parameters:
- DATA_W, 8, number of data bits per frame (>=1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on TXD (>=1).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- TX_VALID  input  1  upstream has a word on TX_DATA.
- TX_DATA  input  DATA_W  word to transmit; sampled only at acceptance.
- TX_READY  output  1  high when a new word can be accepted.
- TXD  output  1  serial line output; idles high.
- BUSY  output  1  high while a frame is in progress (inverse of TX_READY).

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high; asserting it forces the reset state immediately, without waiting for a clock edge.
- Reset values: state=IDLE, TXD=1, TX_READY=1, BUSY=0, bit counter=0, baud counter=0, shift register=0.
- States: IDLE -> START -> DATA -> STOP -> IDLE. With the optional feature enabled, DATA -> PARITY -> STOP.
- Handshake:
  - Acceptance occurs on a rising edge where TX_VALID=1 and TX_READY=1.
  - TX_READY=1 only in IDLE.
  - TX_VALID while busy is ignored; nothing is queued.
  - TX_DATA is latched into the shift register at acceptance; later changes to TX_DATA do not affect the frame in progress.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state and wraps to 0 at the end of each bit.
  - A bit ends on the cycle the counter reaches CLKS_PER_BIT-1.
  - CLKS_PER_BIT=1 must work, giving one cycle per bit.
- TXD is registered:
  - TXD=0 starting on the cycle after acceptance, for CLKS_PER_BIT cycles (START).
  - DATA: TX_DATA[0] first, through TX_DATA[DATA_W-1], each for CLKS_PER_BIT cycles. The shift register shifts right at each bit end; the bit counter runs 0..DATA_W-1.
  - STOP: TXD=1 for CLKS_PER_BIT cycles.
  - IDLE: TXD=1.
- Frame timing:
  - Frame length N = (DATA_W+2)*CLKS_PER_BIT cycles (plus CLKS_PER_BIT with parity).
  - TX_READY goes low the cycle after acceptance and returns high N cycles later.
  - Back-to-back: if TX_VALID is held high, the next word is accepted on the first cycle TX_READY=1. That gives exactly one idle-high cycle between frames.
- Reset mid-frame: the frame is abandoned; TXD returns high immediately and the partial word is discarded.
- Arithmetic: counter widths are $clog2 of their ranges with a minimum width of 1. No truncation warnings are allowed.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA. TXD = XOR of the latched data word (even parity) for CLKS_PER_BIT cycles, and N grows by CLKS_PER_BIT.
- Undefined: no PARITY state exists, and the parity logic is not synthesised.

Decomposition:
- Package serial_frame_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants START_BIT=1'b0 and STOP_BIT=1'b1 (also the line idle level);
  - a function giving the frame length from DATA_W and CLKS_PER_BIT.
- One sub-module, baud_tick_gen: a CLKS_PER_BIT modulo counter.
  - Inputs: enable and clear.
  - Output: a one-cycle bit-end tick.
  - Used by the FSM to advance bits.

Test Plan:
- Reset only, RST=1 for 3 cycles then 0 -> TXD=1, TX_READY=1, BUSY=0 throughout. No activity while TX_VALID=0.
- Accept 8'hA5 (CLKS_PER_BIT=4) -> TXD from the next cycle is 0, 1,0,1,0,0,1,0,1, 1, each for 4 cycles. TX_READY is low for 40 cycles, then high.
- Change TX_DATA to 8'hFF and pulse TX_VALID during the 8'hA5 frame -> transmitted bits are unchanged and no second frame starts.
- TX_VALID held high with 8'h01 then 8'h80 -> two frames separated by exactly one TXD=1 idle cycle; the first data bit of frame two is 0.
- Assert RST asynchronously mid-DATA (between clock edges) -> TXD=1 and TX_READY=1 before the next edge. After release, a new 8'h3C frame transmits correctly.
- With SERIAL_FRAME_TX_PARITY_EN defined, send 8'hA5 -> parity bit 0, frame 44 cycles. Send 8'h07 -> parity bit 1.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared states, line levels and frame length for serial_frame_tx
// SERIAL_FRAME_TX_PARITY_EN adds one parity bit period to the frame length.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int frame_len(input int data_w, input int clks_per_bit);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    return (data_w + 3) * clks_per_bit;
`else
    return (data_w + 2) * clks_per_bit;
`endif
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - modulo-CLKS_PER_BIT counter with a one-cycle bit-end tick
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - start / LSB-first data / stop serial frame transmitter
// Defining SERIAL_FRAME_TX_PARITY_EN inserts an even-parity bit between data and stop.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TX_VALID,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              TX_READY,
  output logic              TXD,
  output logic              BUSY
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n, shifted;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic              txd_q, txd_n;
  logic              tick;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              par_q, par_n;
`endif

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (CLK),
    .rst   (RST),
    .enable(state != IDLE),
    .clear (state == IDLE),
    .tick  (tick)
  );

  assign shifted  = shreg >> 1;
  assign TX_READY = (state == IDLE);
  assign BUSY     = ~TX_READY;
  assign TXD      = txd_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      txd_q   <= STOP_BIT;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      txd_q   <= txd_n;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  // TXD is loaded one bit ahead so the line changes on the same edge the state does.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    txd_n     = txd_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_n     = par_q;
`endif
    case (state)
      IDLE: begin
        txd_n = STOP_BIT;
        if (TX_VALID) begin
          state_n   = START;
          shreg_n   = TX_DATA;
          bit_cnt_n = '0;
          txd_n     = START_BIT;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          par_n     = ^TX_DATA;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          txd_n   = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = shifted;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_n   = PARITY;
            txd_n     = par_q;
`else
            state_n   = STOP;
            txd_n     = STOP_BIT;
`endif
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
            txd_n     = shifted[0];
          end
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          txd_n   = STOP_BIT;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = STOP_BIT;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - scoreboard bench for serial_frame_tx against a bit-list frame model
// Honours SERIAL_FRAME_TX_PARITY_EN when the design is built with it.
module tb_serial_frame_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = DATA_W + 2 + PB;
  localparam int N     = NBITS * CPB;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              TX_VALID = 1'b0;
  logic [DATA_W-1:0] TX_DATA = '0;
  logic              TX_READY, TXD, BUSY;

  serial_frame_tx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .TX_VALID(TX_VALID),
    .TX_DATA (TX_DATA),
    .TX_READY(TX_READY),
    .TXD     (TXD),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] word;
    int                acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   last_acc = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected line level for bit slot k of a frame carrying w.
  function automatic int exp_bit(input logic [DATA_W-1:0] w, input int k);
    if (k == 0) return 0;
    if (k <= DATA_W) return int'((w >> (k - 1)) & 1);
    if (PB == 1 && k == DATA_W + 1) return $countones(w) % 2;
    return 1;
  endfunction

  logic mon_busy = 1'b0;
  exp_t cur;
  int   idx = 0;

  always @(negedge CLK) begin
    if (RST) begin
      mon_busy = 1'b0;
      sb.delete();
    end else begin
      if (!mon_busy && TXD == 1'b0) begin
        if (sb.size() == 0) begin
          check("spurious_frame", 1, 0);
        end else begin
          cur = sb.pop_front();
          check("start_cycle", cyc, cur.acc);
          mon_busy = 1'b1;
          idx = 0;
        end
      end
      if (mon_busy) begin
        if (idx < N) begin
          check("txd_bit", int'(TXD), exp_bit(cur.word, idx / CPB));
          check("ready_low", int'({TX_READY, BUSY}), 1);
          idx++;
        end else begin
          check("ready_return", int'({TX_READY, BUSY}), 2);
          check("idle_gap_txd", int'(TXD), 1);
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] w, input bit keep);
    int waited = 0;
    @(negedge CLK);
    TX_VALID = 1'b1;
    TX_DATA  = w;
    while (TX_READY !== 1'b1 && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 200) begin
      check("ready_timeout", 0, 1);
      TX_VALID = 1'b0;
      return;
    end
    sb.push_back('{w, cyc + 1});
    last_acc = cyc + 1;
    if (!keep) begin
      @(posedge CLK);
      #1;
      TX_VALID = 1'b0;
      TX_DATA  = DATA_W'($urandom);
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || mon_busy) && w < 4 * N) begin
      @(negedge CLK);
      w++;
    end
    if (w >= 4 * N) check("drain_timeout", 0, 1);
    @(negedge CLK);
  endtask

  initial begin
    int a1;
    bit keep;
    repeat (3) begin
      @(negedge CLK);
      check("reset_lines", int'({TXD, TX_READY, BUSY}), 6);
    end
    RST = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      check("idle_lines", int'({TXD, TX_READY, BUSY}), 6);
    end

    send(8'hA5, 1'b0);
    repeat (10) @(negedge CLK);
    TX_DATA  = 8'hFF;
    TX_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    TX_VALID = 1'b0;
    drain();

    send(8'h01, 1'b1);
    a1 = last_acc;
    send(8'h80, 1'b0);
    check("b2b_spacing", last_acc - a1, N + 1);
    drain();

    send(8'h07, 1'b0);
    drain();

    send(8'h5A, 1'b0);
    repeat (3 * CPB) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("async_reset_lines", int'({TXD, TX_READY, BUSY}), 6);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    send(8'h3C, 1'b0);
    drain();

    for (int i = 0; i < 24; i++) begin
      keep = 1'($urandom_range(0, 1));
      send(DATA_W'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 5)) @(negedge CLK);
    end
    @(negedge CLK);
    TX_VALID = 1'b0;
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
